// File: rtl/fpadd_arbiter_pkg.sv
// rtl/fpadd_arbiter_pkg.sv - shared constants and state type for the fpadd arbiter
// Contents: state encodings, FSM state type, quiet-NaN pattern, default watchdog limit.
package fpadd_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/fpadd_arbiter_if.sv
// rtl/fpadd_arbiter_if.sv - bus between the arbiter and the shared fpadd unit
// Signals: fu_start (start/clear), fu_a/fu_b (operands), fu_result, fu_done (sticky).
// master = arbiter side, slave = fpadd side.
interface fpadd_arbiter_if;

  logic        fu_start;
  logic [31:0] fu_a;
  logic [31:0] fu_b;
  logic [31:0] fu_result;
  logic        fu_done;

  modport master (
    output fu_start,
    output fu_a,
    output fu_b,
    input  fu_result,
    input  fu_done
  );

  modport slave (
    input  fu_start,
    input  fu_a,
    input  fu_b,
    output fu_result,
    output fu_done
  );

endinterface

// File: rtl/fpadd_arbiter_rr_pick.sv
// rtl/fpadd_arbiter_rr_pick.sv - combinational round-robin picker
// Ports: req (request vector), rr_ptr (highest-priority index),
//        gnt_valid (any request), gnt_id (first set bit at or above rr_ptr, wrapping).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_id
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  always_comb begin
    // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set
    // bit of rot is the offset of the winner from rr_ptr.
    rot       = NUM_REQ'({req, req} >> rr_ptr);
    gnt_valid = 1'b0;
    off       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_valid = 1'b1;
        off       = IDX_W'(k);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
      sum = sum - (IDX_W + 1)'(NUM_REQ);
    end
    gnt_id = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// rtl/fpadd_arbiter.sv - round-robin sharing of one fpadd unit between NUM_REQ requesters
// Ports: clk, reset (sync, active-high); req/req_a/req_b (requester side, 32-bit slices);
//        ack (one-hot pulse); resp_valid/resp_id/resp_data/resp_err (result pulse);
//        busy; fu (master side of the fpadd bus).
module fpadd_arbiter
  import fpadd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  resp_valid,
  output logic [IDX_W-1:0]      resp_id,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic                  busy,
  fpadd_arbiter_if.master       fu
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_id;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [7:0]       wd_cnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_id;
  logic             wd_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  assign wd_expired = (wd_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_valid) state_nxt = START;
      START: state_nxt = WAIT;
      // A done seen on the expiry cycle still takes the normal path.
      WAIT:  if (fu.fu_done || wd_expired) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding fu_start during reset keeps the unit cleared.
  assign fu.fu_start = reset | (state == START);
  assign fu.fu_a     = a_q;
  assign fu.fu_b     = b_q;
  assign ack         = (state == START) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign resp_valid  = (state == RESP);
  assign resp_id     = (state == RESP) ? gnt_id : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wd_cnt    <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            a_q    <= req_a[32*pick_id +: 32];
            b_q    <= req_b[32*pick_id +: 32];
            gnt_id <= pick_id;
            rr_ptr <= (pick_id == IDX_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
          end
        end
        START: wd_cnt <= '0;
        WAIT: begin
          if (fu.fu_done) begin
            resp_data <= fu.fu_result;
            resp_err  <= 1'b0;
          end else if (wd_expired) begin
            resp_data <= FP_QNAN;
            resp_err  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb/tb_fpadd_arbiter.sv - self-checking bench for fpadd_arbiter with a behavioural fpadd unit
module tb_fpadd_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  logic [N-1:0]      ack;
  logic              resp_valid;
  logic [IDX_W-1:0]  resp_id;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              busy;

  fpadd_arbiter_if fu_bus ();

  fpadd_arbiter #(.NUM_REQ(N), .IDX_W(IDX_W), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .ack        (ack),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .fu         (fu_bus)
  );

  always #5 clk = ~clk;

  logic [31:0] opa [N];
  logic [31:0] opb [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = opa[i];
      req_b[32*i +: 32] = opb[i];
    end
  end

  // Single-precision <-> real for normal numbers and zero.
  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real s2r(logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'd0) return 0.0;
    e = 11'(s[30:23]) + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fsum(logic [31:0] a, logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [31:0] rnd_op();
    int n;
    n = int'($urandom_range(1, 1000));
    return ($urandom_range(0, 1) == 1) ? r2s(-real'(n)) : r2s(real'(n));
  endfunction

  // Behavioural fpadd: result after a latency, done sticky until next start.
  int          u_cnt;
  logic [31:0] u_res;
  int          lat_force = 0;
  bit          hang = 1'b0;

  always @(posedge clk) begin
    if (fu_bus.fu_start) begin
      fu_bus.fu_done <= 1'b0;
      u_res <= fsum(fu_bus.fu_a, fu_bus.fu_b);
      u_cnt <= hang ? 0 : ((lat_force != 0) ? lat_force : int'($urandom_range(1, 6)));
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        fu_bus.fu_done   <= 1'b1;
        fu_bus.fu_result <= u_res;
      end
    end
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t         expq[$];
  int           ack_log[$];
  int           checks = 0;
  int           errors = 0;
  int           mptr = 0;
  int           n_acks = 0;
  int           n_resps = 0;
  int           cyc = 0;
  int           ack_cyc = 0;
  int           resp_cyc = 0;
  logic [31:0]  last_data;
  logic         last_err;
  bit           persist [N];
  bit           expect_err = 1'b0;
  bit           in_op = 1'b0;
  logic [31:0]  cur_a;
  logic [31:0]  cur_b;
  logic [N-1:0] req_at_edge;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic observe();
    int w;
    logic [N-1:0] ev;
    exp_t e;
    if (reset) return;
    if (ack !== '0) begin
      w  = pick(req_at_edge, mptr);
      ev = (w < 0) ? '0 : (N'(1) << w);
      chk("ack_grant", ack, ev);
      if (w >= 0) begin
        mptr = (w + 1) % N;
        e.id   = w;
        e.err  = expect_err;
        e.data = expect_err ? 32'h7FC0_0000 : fsum(opa[w], opb[w]);
        expq.push_back(e);
        ack_log.push_back(w);
        n_acks++;
        ack_cyc = cyc;
        cur_a = opa[w];
        cur_b = opb[w];
        in_op = 1'b1;
        if (persist[w]) begin
          opa[w] = rnd_op();
          opb[w] = rnd_op();
        end else begin
          req[w] = 1'b0;
        end
      end
    end
    if (in_op) begin
      chk("fu_a_hold", fu_bus.fu_a, cur_a);
      chk("fu_b_hold", fu_bus.fu_b, cur_b);
    end
    if (resp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("resp_id", resp_id, e.id);
        chk("resp_data", resp_data, e.data);
        chk("resp_err", resp_err, e.err);
      end
      last_data = resp_data;
      last_err  = resp_err;
      resp_cyc  = cyc;
      n_resps++;
      in_op = 1'b0;
    end
  endtask

  task automatic tick();
    req_at_edge = req;
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int start;
    int c;
    start = n_acks;
    c = 0;
    while (n_acks - start < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, n_acks - start, n);
  endtask

  task automatic wait_resps(input int n, input int budget, input string tag);
    int start;
    int c;
    start = n_resps;
    c = 0;
    while (n_resps - start < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, n_resps - start, n);
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((req !== '0 || busy !== 1'b0 || expq.size() != 0) && c < 600) begin
      tick();
      c++;
    end
    chk(tag, {req != '0, busy, expq.size() != 0}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    chk("rst_fu_start", fu_bus.fu_start, 1'b1);
    chk("rst_no_resp", resp_valid, 1'b0);
    reset = 1'b0;
    mptr = 0;
    in_op = 1'b0;
    expq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int base;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
      persist[i] = 1'b0;
    end

    // Reset state
    tick();
    tick();
    do_reset();
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_fu_a", fu_bus.fu_a, 0);
    chk("rst_fu_b", fu_bus.fu_b, 0);
    chk("rst_fu_start_low", fu_bus.fu_start, 0);

    // Single op: 1.0 + 2.0 from requester 2
    opa[2] = 32'h3F80_0000;
    opb[2] = 32'h4000_0000;
    req[2] = 1'b1;
    tick();
    chk("single_ack", ack, 4'b0100);
    chk("single_fu_start", fu_bus.fu_start, 1);
    wait_resps(1, 20, "single_resp_seen");
    chk("single_data", last_data, 32'h4040_0000);
    chk("single_err", last_err, 0);
    tick();
    chk("single_idle", busy, 0);

    // Cancellation to +0
    opa[0] = 32'h3F80_0000;
    opb[0] = 32'hBF80_0000;
    req[0] = 1'b1;
    wait_resps(1, 20, "cancel_resp_seen");
    chk("cancel_data", last_data, 32'h0);
    chk("cancel_err", last_err, 0);
    drain("cancel_drain");

    // Contention from a fresh pointer
    do_reset();
    tick();
    for (int i = 0; i < N; i++) begin
      opa[i] = rnd_op();
      opb[i] = rnd_op();
    end
    base = ack_log.size();
    req = 4'hF;
    wait_acks(4, 60, "contend_acks");
    for (int k = 0; k < 4; k++) chk($sformatf("contend_order%0d", k), ack_log[base + k], k);
    drain("contend_drain");

    // Wrap and fairness: move pointer to 3, then 3 and 0 hold req
    opa[2] = rnd_op();
    opb[2] = rnd_op();
    req[2] = 1'b1;
    wait_resps(1, 20, "wrap_pre");
    drain("wrap_pre_drain");
    persist[3] = 1'b1;
    persist[0] = 1'b1;
    opa[3] = rnd_op(); opb[3] = rnd_op();
    opa[0] = rnd_op(); opb[0] = rnd_op();
    base = ack_log.size();
    req[3] = 1'b1;
    req[0] = 1'b1;
    wait_acks(6, 80, "wrap_acks");
    for (int k = 0; k < 6; k++) chk($sformatf("wrap_order%0d", k), ack_log[base + k], (k % 2 == 0) ? 3 : 0);
    persist[3] = 1'b0;
    persist[0] = 1'b0;
    drain("wrap_drain");

    // Lone requester gets every slot
    persist[1] = 1'b1;
    opa[1] = rnd_op(); opb[1] = rnd_op();
    base = ack_log.size();
    req[1] = 1'b1;
    wait_acks(3, 60, "lone_acks");
    for (int k = 0; k < 3; k++) chk($sformatf("lone_order%0d", k), ack_log[base + k], 1);
    persist[1] = 1'b0;
    drain("lone_drain");

    // Watchdog expiry
    hang = 1'b1;
    expect_err = 1'b1;
    opa[1] = rnd_op(); opb[1] = rnd_op();
    req[1] = 1'b1;
    wait_acks(1, 10, "wd_ack");
    wait_resps(1, 40, "wd_resp");
    chk("wd_latency", resp_cyc - ack_cyc, 16);
    chk("wd_data", last_data, 32'h7FC0_0000);
    chk("wd_err", last_err, 1);
    tick();
    chk("wd_idle", busy, 0);
    hang = 1'b0;

    // Done on the expiry cycle wins; one cycle later loses
    lat_force = 14;
    expect_err = 1'b0;
    opa[3] = rnd_op(); opb[3] = rnd_op();
    req[3] = 1'b1;
    wait_acks(1, 10, "edge14_ack");
    wait_resps(1, 40, "edge14_resp");
    chk("edge14_latency", resp_cyc - ack_cyc, 16);
    chk("edge14_err", last_err, 0);
    drain("edge14_drain");
    lat_force = 15;
    expect_err = 1'b1;
    opa[0] = rnd_op(); opb[0] = rnd_op();
    req[0] = 1'b1;
    wait_acks(1, 10, "edge15_ack");
    wait_resps(1, 40, "edge15_resp");
    chk("edge15_latency", resp_cyc - ack_cyc, 16);
    chk("edge15_err", last_err, 1);
    drain("edge15_drain");
    lat_force = 0;
    expect_err = 1'b0;

    // Randomised traffic
    for (int t = 0; t < 400; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          opa[i] = rnd_op();
          opb[i] = rnd_op();
          persist[i] = ($urandom_range(0, 3) == 0);
          req[i] = 1'b1;
        end else if (req[i] && !persist[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) persist[i] = 1'b0;
    drain("random_drain");

    // Reset in the middle of WAIT
    lat_force = 10;
    opa[2] = rnd_op(); opb[2] = rnd_op();
    req[2] = 1'b1;
    wait_acks(1, 10, "rstw_ack");
    tick();
    tick();
    tick();
    chk("rstw_in_wait", busy, 1);
    do_reset();
    lat_force = 0;
    for (int k = 0; k < 20; k++) tick();
    chk("rstw_busy", busy, 0);
    opa[1] = rnd_op(); opb[1] = rnd_op();
    opa[3] = rnd_op(); opb[3] = rnd_op();
    req[1] = 1'b1;
    req[3] = 1'b1;
    tick();
    chk("rstw_regrant", ack, 4'b0010);
    drain("rstw_drain");
    chk("final_queue", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
- Shares one fpadd unit between NUM_REQ requesters (e.g. voice/DSP channels) using a round-robin, one-op-at-a-time scheme.
- Latches the granted requester's operands and pulses the unit's start/clear input. It then waits for the unit's sticky done and returns the sum tagged with the requester index.
- A watchdog bounds each operation. If it expires, the block returns a qNaN with an error flag.
- Sits between channel logic and a single fpadd instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the requester index; must satisfy 2**IDX_W >= NUM_REQ.
- TIMEOUT, 15, maximum WAIT cycles before abort (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until that requester's ack.
- req_a  in  NUM_REQ*32  flattened operand A buses; requester i occupies [32*i+31:32*i].
- req_b  in  NUM_REQ*32  flattened operand B buses, same packing.
- ack  out  NUM_REQ  one-hot, one-cycle pulse: operands taken.
- resp_valid  out  1  one-cycle pulse: result available.
- resp_id  out  IDX_W  index of the requester that owns the result.
- resp_data  out  32  IEEE-754 single-precision result.
- resp_err  out  1  high with resp_valid when the watchdog expired.
- busy  out  1  high in any state other than IDLE.
- fu_start  out  1  drives the fpadd reset/start input.
- fu_a  out  32  latched operand A to fpadd dataa.
- fu_b  out  32  latched operand B to fpadd datab.
- fu_result  in  32  fpadd result.
- fu_done  in  1  fpadd done; sticky until the next fu_start.

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE, rr_ptr=0, ack=0, resp_valid=0, resp_err=0, resp_id=0, resp_data=0, fu_a=0, fu_b=0, wd_cnt=0.
  - fu_start = reset | (state==START), so the unit is held cleared during reset.
  - A reset in the middle of an operation aborts it. No response is emitted and the pending requester is not acked again.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If req is nonzero, grant the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On that edge: latch fu_a/fu_b from the granted slice, latch gnt_id, set rr_ptr=(gnt_id+1) mod NUM_REQ, go to START.
  - If req is zero, stay in IDLE; rr_ptr is unchanged.
- START (exactly 1 cycle):
  - fu_start=1 and ack[gnt_id]=1.
  - wd_cnt cleared. Go to WAIT.
- WAIT:
  - fu_start=0. fu_done is sampled every cycle.
  - If fu_done=1: resp_data<=fu_result, resp_err<=0, go to RESP.
  - Otherwise wd_cnt increments. When wd_cnt reaches TIMEOUT-1 with fu_done still 0: resp_data<=32'h7FC00000, resp_err<=1, go to RESP.
  - A fu_done arriving on the same cycle as expiry wins: the real result is returned with err=0.
- RESP (1 cycle):
  - resp_valid=1 and resp_id=gnt_id. Return to IDLE.
- fu_a and fu_b stay constant from START until IDLE re-grants.
- Latency and throughput:
  - Request to ack is 1 cycle.
  - fu_start to resp_valid is (fpadd cycles)+1.
  - Minimum 4 cycles between successive grants.
- Requester rules:
  - Requester must deassert req no later than the cycle after ack.
  - A req that falls before grant is simply not serviced.
  - A req held after ack is treated as a new request.
- Fairness:
  - With all requesters asserting, grants go in strict rotation 0,1,2,3,0,…
  - A lone requester is granted every slot; the pointer wrap from NUM_REQ-1 to 0 is exercised.
- Width rules:
  - The upward search is done over NUM_REQ bits using a doubled request vector, then index-reduced.
  - resp_id is zero-extended when NUM_REQ < 2**IDX_W.

Decomposition:
- Shared package fpadd_arb_pkg contains:
  - State encoding localparams ST_IDLE, ST_START, ST_WAIT, ST_RESP.
  - FP_QNAN = 32'h7FC00000.
  - The default TIMEOUT.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req and rr_ptr.
  - Outputs: gnt_valid and gnt_id.
  - Reusable by later shared DSP units (multiplier, divider).
- The FSM, operand latches and watchdog stay in fpadd_arbiter.

Test Plan:
- Single op: req[2]=1, a=3F800000 (1.0), b=40000000 (2.0).
  - Required: ack=0100 one cycle later, then resp_valid with id=2, data=40400000 (3.0), err=0.
- Cancellation: req[0]=1, a=3F800000, b=BF800000.
  - Required: resp data=00000000, err=0.
- Contention: all four req high, each with distinct operands, held until ack.
  - Required: acks in order 0,1,2,3; resp_ids in the same order; each resp_data matches its operands.
- Wrap and fairness: req[3] and req[0] asserted continuously.
  - Required: grants alternate 3,0,3,0; rr_ptr wraps to 0 after index 3.
- Watchdog: TIMEOUT=15 and fu_done forced to 0.
  - Required: resp_valid exactly 15 WAIT cycles after START, data=7FC00000, err=1, FSM back in IDLE.
- Reset in WAIT: assert reset for one cycle mid-operation.
  - Required: no resp_valid, busy=0, rr_ptr=0, fu_start=1 during the reset cycle, and the next request is granted normally.
